dac_frame_rx: RTL and testbench

- Receiving end of the DAC serial link: a 3-wire frame receiver for sync / dac_clk / dac_in.
- Oversamples the link in the system clock domain and deserializes MSB-first words.
- Outputs each word with a one-cycle valid strobe and reports malformed frames.
- Used as on-chip loopback monitor of the DAC serializer output and as the checker model in system benches.

---
 rtl/dac_frame_rx.sv | 158 +++++++++++++++
 tb/tb_dac_frame_rx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_frame_rx.sv
// Receiver for the 3-wire DAC link (sync / dac_clk / dac_in): oversamples the
// link in the clk domain, deserializes MSB-first words and flags malformed frames.
module dac_frame_rx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_RISE = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync,
  input  logic              dac_clk,
  input  logic              dac_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic [15:0]       frame_cnt,
  output logic              busy
);

  localparam int BCW = $clog2(DATA_W + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W - 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_END, ABORT} state_t;

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic [SYNC_STAGES-1:0] clk_pipe;
  logic [SYNC_STAGES-1:0] din_pipe;
  logic                   sync_hist;
  logic                   clk_hist;
  logic [SYNC_STAGES:0]   prime;

  // prime fills with ones as real input samples reach the history flop; edges
  // are ignored until then so a sync already low at reset release is not a start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_pipe <= '1;
      clk_pipe  <= '0;
      din_pipe  <= '0;
      sync_hist <= 1'b1;
      clk_hist  <= 1'b0;
      prime     <= '0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], sync};
      clk_pipe  <= {clk_pipe[SYNC_STAGES-2:0], dac_clk};
      din_pipe  <= {din_pipe[SYNC_STAGES-2:0], dac_in};
      sync_hist <= sync_pipe[SYNC_STAGES-1];
      clk_hist  <= clk_pipe[SYNC_STAGES-1];
      prime     <= {prime[SYNC_STAGES-1:0], 1'b1};
    end
  end

  logic sync_s, clk_s, din_s, ready;
  logic sync_fall, sync_rise, sample;

  assign sync_s    = sync_pipe[SYNC_STAGES-1];
  assign clk_s     = clk_pipe[SYNC_STAGES-1];
  assign din_s     = din_pipe[SYNC_STAGES-1];
  assign ready     = prime[SYNC_STAGES];
  assign sync_fall = ready & sync_hist & ~sync_s;
  assign sync_rise = ready & ~sync_hist & sync_s;
  assign sample    = ready & ((SAMPLE_RISE != 0) ? (clk_s & ~clk_hist) : (~clk_s & clk_hist));

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shifted;
  logic [BCW-1:0]    bit_cnt;
  logic [TCW-1:0]    tmo_cnt;

  assign shifted = {shift_reg[DATA_W-2:0], din_s};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'b00;
      frame_cnt <= 16'd0;
      busy      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_fall) begin
            state     <= SHIFT;
            busy      <= 1'b1;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tmo_cnt   <= '0;
          end
        end
        SHIFT: begin
          if (sample) begin
            shift_reg <= shifted;
            tmo_cnt   <= '0;
            bit_cnt   <= bit_cnt + 1'b1;
            // The last sample wins over a coincident sync rise.
            if (bit_cnt == BIT_LAST) begin
              rx_data   <= shifted;
              rx_valid  <= 1'b1;
              frame_cnt <= frame_cnt + 16'd1;
              if (sync_rise) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= WAIT_END;
              end
            end else if (sync_rise) begin
              frame_err <= 1'b1;
              err_code  <= 2'b01;
              state     <= IDLE;
              busy      <= 1'b0;
            end
          end else if (sync_rise) begin
            frame_err <= 1'b1;
            err_code  <= 2'b01;
            state     <= IDLE;
            busy      <= 1'b0;
          end else if (tmo_cnt == TMO_LAST) begin
            frame_err <= 1'b1;
            err_code  <= 2'b11;
            state     <= ABORT;
            busy      <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WAIT_END: begin
          if (sync_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (sample) begin
            frame_err <= 1'b1;
            err_code  <= 2'b10;
            state     <= ABORT;
            busy      <= 1'b0;
          end
        end
        ABORT: begin
          if (sync_s) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_frame_rx.sv
// Randomized bench for dac_frame_rx: frames are driven on the 3-wire link and the
// observed strobes are compared with events predicted from frame-level rules.
module tb_dac_frame_rx;
  localparam int DW  = 16;
  localparam int SS  = 2;
  localparam int TMO = 255;
  localparam int LAT = SS + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sync = 1'b1;
  logic        dac_clk = 1'b0;
  logic        dac_in = 1'b0;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;
  logic        busy;

  dac_frame_rx #(.DATA_W(DW), .SYNC_STAGES(SS), .SAMPLE_RISE(1), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .sync(sync), .dac_clk(dac_clk), .dac_in(dac_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .err_code(err_code), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_err;
    logic [15:0] data;
    logic [1:0]  code;
    logic [31:0] cyc;
  } ev_t;

  int  cyc = 0;
  int  vectors = 0;
  int  errors = 0;
  ev_t got_q[$];
  ev_t exp_q[$];
  int  rise_cyc[$];
  int  sync_rise_cyc;

  // Reference state: what the receiver should be holding after the frames so far.
  logic [15:0] m_data = '0;
  logic [15:0] m_cnt = '0;
  logic [1:0]  m_code = '0;

  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (rx_valid) begin
      got_q.push_back('{1'b0, rx_data, 2'b00, 32'(cyc)});
      $display("cyc %0d: rx_valid data=%h frame_cnt=%0d", cyc, rx_data, frame_cnt);
    end
    if (frame_err) begin
      got_q.push_back('{1'b1, 16'h0000, err_code, 32'(cyc)});
      $display("cyc %0d: frame_err code=%0d", cyc, err_code);
    end
    if (rx_valid && frame_err) begin
      errors++;
      $display("FAIL strobe_overlap at cyc %0d: rx_valid=1 frame_err=1, required not both", cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one sync-low window. Must be called right after a negedge.
  task automatic run_frame(input logic [15:0] word, input int nbits, input bit stall,
                           input bit rise_with_last, input int gap);
    rise_cyc.delete();
    sync = 1'b0;
    dac_clk = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i < DW) dac_in = word[DW-1-i];
      else        dac_in = 1'($urandom);
      repeat (4) @(negedge clk);
      dac_clk = 1'b1;
      rise_cyc.push_back(cyc);
      if (rise_with_last && i == nbits - 1) begin
        sync = 1'b1;
        sync_rise_cyc = cyc;
      end
      repeat (4) @(negedge clk);
      dac_clk = 1'b0;
    end
    if (stall) repeat (TMO + SS + 20) @(negedge clk);
    if (!rise_with_last) begin
      repeat (4) @(negedge clk);
      sync = 1'b1;
      sync_rise_cyc = cyc;
    end
    repeat (gap) @(negedge clk);
  endtask

  // Frame-level rules: <DW edges is short, exactly DW is a word, >DW is a word then
  // long; a stalled clock aborts TMO cycles after the last sample reaches the FSM.
  task automatic model_frame(input logic [15:0] word, input int nbits, input bit stall);
    if (stall) begin
      exp_q.push_back('{1'b1, 16'h0000, 2'b11, 32'(rise_cyc[nbits-1] + LAT + TMO)});
      m_code = 2'b11;
    end else if (nbits < DW) begin
      exp_q.push_back('{1'b1, 16'h0000, 2'b01, 32'(sync_rise_cyc + LAT)});
      m_code = 2'b01;
    end else begin
      exp_q.push_back('{1'b0, word, 2'b00, 32'(rise_cyc[DW-1] + LAT)});
      m_data = word;
      m_cnt  = m_cnt + 16'd1;
      if (nbits > DW) begin
        exp_q.push_back('{1'b1, 16'h0000, 2'b10, 32'(rise_cyc[DW] + LAT)});
        m_code = 2'b10;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (rx_data !== 16'h0)   begin errors++; $display("FAIL reset_rx_data got %h required 0000", rx_data); end
    vectors++; if (rx_valid !== 1'b0)   begin errors++; $display("FAIL reset_rx_valid got %b required 0", rx_valid); end
    vectors++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL reset_frame_err got %b required 0", frame_err); end
    vectors++; if (err_code !== 2'b00)  begin errors++; $display("FAIL reset_err_code got %b required 00", err_code); end
    vectors++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL reset_frame_cnt got %0d required 0", frame_cnt); end
    vectors++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
    rst = 1'b1;
    repeat (8) @(negedge clk);
    vectors++; if (got_q.size() != 0)   begin errors++; $display("FAIL reset_no_events got %0d events required 0", got_q.size()); end
    vectors++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy_after got %b required 0", busy); end
  endtask

  task automatic test_single();
    run_frame(16'hA5C3, DW, 1'b0, 1'b0, 4);
    model_frame(16'hA5C3, DW, 1'b0);
    repeat (10) @(negedge clk);
    vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL single_event_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_event[%0d] got %h required %h", i, got_q[i], exp_q[i]); end
    end
    vectors++; if (rx_data !== m_data)  begin errors++; $display("FAIL single_rx_data got %h required %h", rx_data, m_data); end
    vectors++; if (frame_cnt !== m_cnt) begin errors++; $display("FAIL single_frame_cnt got %0d required %0d", frame_cnt, m_cnt); end
    vectors++; if (busy !== 1'b0)       begin errors++; $display("FAIL single_busy got %b required 0", busy); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    words[0] = 16'h0000; words[1] = 16'hFFFF; words[2] = 16'h8001;
    for (int f = 0; f < 3; f++) begin
      run_frame(words[f], DW, 1'b0, 1'b0, 2);
      model_frame(words[f], DW, 1'b0);
    end
    repeat (10) @(negedge clk);
    vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_event_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_event[%0d] got %h required %h", i, got_q[i], exp_q[i]); end
    end
    vectors++; if (frame_cnt !== m_cnt) begin errors++; $display("FAIL b2b_frame_cnt got %0d required %0d", frame_cnt, m_cnt); end
    vectors++; if (rx_data !== m_data)  begin errors++; $display("FAIL b2b_rx_data got %h required %h", rx_data, m_data); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_short_and_long();
    logic [15:0] w;
    w = 16'($urandom);
    run_frame(w, DW, 1'b0, 1'b0, 4);
    model_frame(w, DW, 1'b0);
    run_frame(16'($urandom), 10, 1'b0, 1'b0, 4);
    model_frame(16'h0000, 10, 1'b0);
    vectors++; if (err_code !== m_code) begin errors++; $display("FAIL short_err_code got %b required %b", err_code, m_code); end
    vectors++; if (rx_data !== m_data)  begin errors++; $display("FAIL short_rx_data_held got %h required %h", rx_data, m_data); end
    run_frame(16'h1234, DW + 1, 1'b0, 1'b0, 4);
    model_frame(16'h1234, DW + 1, 1'b0);
    repeat (10) @(negedge clk);
    vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL shortlong_event_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL shortlong_event[%0d] got %h required %h", i, got_q[i], exp_q[i]); end
    end
    vectors++; if (err_code !== m_code) begin errors++; $display("FAIL long_err_code got %b required %b", err_code, m_code); end
    vectors++; if (rx_data !== m_data)  begin errors++; $display("FAIL long_rx_data got %h required %h", rx_data, m_data); end
    vectors++; if (frame_cnt !== m_cnt) begin errors++; $display("FAIL long_frame_cnt got %0d required %0d", frame_cnt, m_cnt); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    run_frame(16'($urandom), 5, 1'b1, 1'b0, 4);
    model_frame(16'h0000, 5, 1'b1);
    run_frame(16'h00FF, DW, 1'b0, 1'b0, 4);
    model_frame(16'h00FF, DW, 1'b0);
    repeat (10) @(negedge clk);
    vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL timeout_event_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL timeout_event[%0d] got %h required %h", i, got_q[i], exp_q[i]); end
    end
    vectors++; if (err_code !== m_code) begin errors++; $display("FAIL timeout_err_code got %b required %b", err_code, m_code); end
    vectors++; if (rx_data !== m_data)  begin errors++; $display("FAIL timeout_rx_data got %h required %h", rx_data, m_data); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_simultaneous();
    logic [15:0] w0, w1;
    w0 = 16'($urandom); w1 = 16'($urandom);
    run_frame(w0, DW, 1'b0, 1'b1, 4);
    model_frame(w0, DW, 1'b0);
    run_frame(w1, DW, 1'b0, 1'b0, 4);
    model_frame(w1, DW, 1'b0);
    repeat (10) @(negedge clk);
    vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL simul_event_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL simul_event[%0d] got %h required %h", i, got_q[i], exp_q[i]); end
    end
    vectors++; if (frame_cnt !== m_cnt) begin errors++; $display("FAIL simul_frame_cnt got %0d required %0d", frame_cnt, m_cnt); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    sync = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      dac_in = 1'($urandom);
      repeat (4) @(negedge clk);
      dac_clk = 1'b1;
      repeat (4) @(negedge clk);
      dac_clk = 1'b0;
    end
    #3 rst = 1'b0;
    #1;
    m_data = '0; m_cnt = '0; m_code = '0;
    vectors++; if (rx_data !== 16'h0)   begin errors++; $display("FAIL midrst_rx_data got %h required 0000", rx_data); end
    vectors++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL midrst_frame_cnt got %0d required 0", frame_cnt); end
    vectors++; if (err_code !== 2'b00)  begin errors++; $display("FAIL midrst_err_code got %b required 00", err_code); end
    vectors++; if (busy !== 1'b0)       begin errors++; $display("FAIL midrst_busy got %b required 0", busy); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    // Released with sync still low: these edges must not start a frame.
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge clk);
      dac_clk = 1'b1;
      repeat (4) @(negedge clk);
      dac_clk = 1'b0;
    end
    vectors++; if (busy !== 1'b0)       begin errors++; $display("FAIL midrst_no_start got busy=%b required 0", busy); end
    repeat (4) @(negedge clk);
    sync = 1'b1;
    repeat (4) @(negedge clk);
    run_frame(16'h7E7E, DW, 1'b0, 1'b0, 4);
    model_frame(16'h7E7E, DW, 1'b0);
    repeat (10) @(negedge clk);
    vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL midrst_event_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_event[%0d] got %h required %h", i, got_q[i], exp_q[i]); end
    end
    vectors++; if (rx_data !== m_data)  begin errors++; $display("FAIL midrst_rx_data_after got %h required %h", rx_data, m_data); end
    vectors++; if (frame_cnt !== m_cnt) begin errors++; $display("FAIL midrst_frame_cnt_after got %0d required %0d", frame_cnt, m_cnt); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    for (int f = 0; f < 10; f++) begin
      logic [15:0] w;
      int n;
      w = 16'($urandom);
      n = $urandom_range(18, 8);
      run_frame(w, n, 1'b0, 1'b0, $urandom_range(6, 2));
      model_frame(w, n, 1'b0);
    end
    repeat (10) @(negedge clk);
    vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL random_event_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_event[%0d] got %h required %h", i, got_q[i], exp_q[i]); end
    end
    vectors++; if (rx_data !== m_data)  begin errors++; $display("FAIL random_rx_data got %h required %h", rx_data, m_data); end
    vectors++; if (frame_cnt !== m_cnt) begin errors++; $display("FAIL random_frame_cnt got %0d required %0d", frame_cnt, m_cnt); end
    vectors++; if (err_code !== m_code) begin errors++; $display("FAIL random_err_code got %b required %b", err_code, m_code); end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_single();
    test_back_to_back();
    test_short_and_long();
    test_timeout();
    test_simultaneous();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
